// File: rtl/packed_lane_loader.sv
// Streams bytes from four round-robin-arbitrated requesters into per-bank shadow
// registers and publishes each completed bank atomically to its packed output.
module packed_lane_loader #(
    parameter int W = 8,
    parameter int K = 4
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic [3:0]          req_valid,
    input  logic [3:0][7:0]     req_data,
    output logic [3:0]          req_ready,
    output logic [1:0]          grant,
    output logic                busy,
    output logic [3:0]          bank_done,
    output logic [W+K-1:0][7:0] add_left,
    output logic [W-K-1:0][7:0] substract_left,
    output logic [W*K-1:0][7:0] multiply_left,
    output logic [W/K-1:0][7:0] divide_left
);
    localparam int D0 = W + K;
    localparam int D1 = W - K;
    localparam int D2 = W * K;
    localparam int D3 = W / K;
    localparam int CW = $clog2(W * K);

    typedef enum logic [1:0] {IDLE, ARB, LOAD, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      last_grant;
    logic [1:0]      arb_pick;
    logic [1:0]      arb_idx;
    logic            arb_found;
    logic [CW-1:0]   lane_cnt;
    logic [CW-1:0]   last_lane;
    logic            hs;
    logic            last_hs;

    logic [D0-1:0][7:0] shadow_add;
    logic [D1-1:0][7:0] shadow_sub;
    logic [D2-1:0][7:0] shadow_mul;
    logic [D3-1:0][7:0] shadow_div;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        arb_pick  = 2'd0;
        arb_found = 1'b0;
        arb_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            arb_idx = last_grant + 2'(i);
            if (!arb_found && req_valid[arb_idx]) begin
                arb_pick  = arb_idx;
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        case (grant)
            2'd0:    last_lane = CW'(D0 - 1);
            2'd1:    last_lane = CW'(D1 - 1);
            2'd2:    last_lane = CW'(D2 - 1);
            default: last_lane = CW'(D3 - 1);
        endcase
    end

    assign hs      = (state == LOAD) && req_valid[grant] && req_ready[grant];
    assign last_hs = hs && (lane_cnt == last_lane);

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (|req_valid) state_nxt = ARB;
            ARB:     state_nxt = arb_found ? LOAD : IDLE;
            LOAD:    if (last_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state          <= IDLE;
            grant          <= 2'd0;
            last_grant     <= 2'd3;
            lane_cnt       <= '0;
            req_ready      <= 4'b0000;
            bank_done      <= 4'b0000;
            shadow_add     <= '0;
            shadow_sub     <= '0;
            shadow_mul     <= '0;
            shadow_div     <= '0;
            add_left       <= '0;
            substract_left <= '0;
            multiply_left  <= '0;
            divide_left    <= '0;
        end else begin
            state     <= state_nxt;
            req_ready <= 4'b0000;
            bank_done <= 4'b0000;
            case (state)
                ARB: begin
                    if (arb_found) begin
                        grant     <= arb_pick;
                        lane_cnt  <= '0;
                        req_ready <= 4'b0001 << arb_pick;
                    end
                end
                LOAD: begin
                    if (!last_hs) req_ready <= 4'b0001 << grant;
                    if (hs) begin
                        case (grant)
                            2'd0: for (int i = 0; i < D0; i++)
                                if (lane_cnt == CW'(i)) shadow_add[i] <= req_data[0];
                            2'd1: for (int i = 0; i < D1; i++)
                                if (lane_cnt == CW'(i)) shadow_sub[i] <= req_data[1];
                            2'd2: for (int i = 0; i < D2; i++)
                                if (lane_cnt == CW'(i)) shadow_mul[i] <= req_data[2];
                            default: for (int i = 0; i < D3; i++)
                                if (lane_cnt == CW'(i)) shadow_div[i] <= req_data[3];
                        endcase
                        if (last_hs) begin
                            // Publish on the final handshake so the new bank is visible in DONE;
                            // the last lane comes straight from the bus.
                            bank_done <= 4'b0001 << grant;
                            case (grant)
                                2'd0: begin
                                    add_left         <= shadow_add;
                                    add_left[D0-1]   <= req_data[0];
                                end
                                2'd1: begin
                                    substract_left       <= shadow_sub;
                                    substract_left[D1-1] <= req_data[1];
                                end
                                2'd2: begin
                                    multiply_left       <= shadow_mul;
                                    multiply_left[D2-1] <= req_data[2];
                                end
                                default: begin
                                    divide_left       <= shadow_div;
                                    divide_left[D3-1] <= req_data[3];
                                end
                            endcase
                        end else begin
                            lane_cnt <= lane_cnt + CW'(1);
                        end
                    end
                end
                DONE: last_grant <= grant;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_packed_lane_loader.sv
// Bench for packed_lane_loader: directed scenarios plus randomized bursts, checked
// against a stream/burst-level model of arbitration, lane filling and publishing.
module tb_packed_lane_loader;
    localparam int W  = 8;
    localparam int K  = 4;
    localparam int D0 = W + K;
    localparam int D1 = W - K;
    localparam int D2 = W * K;
    localparam int D3 = W / K;

    logic                clk = 1'b0;
    logic                reset_l;
    logic [3:0]          req_valid;
    logic [3:0][7:0]     req_data;
    logic [3:0]          req_ready;
    logic [1:0]          grant;
    logic                busy;
    logic [3:0]          bank_done;
    logic [D0-1:0][7:0]  add_left;
    logic [D1-1:0][7:0]  substract_left;
    logic [D2-1:0][7:0]  multiply_left;
    logic [D3-1:0][7:0]  divide_left;

    always #5 clk = ~clk;

    packed_lane_loader #(.W(W), .K(K)) dut (
        .clk(clk), .reset_l(reset_l), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant(grant), .busy(busy), .bank_done(bank_done),
        .add_left(add_left), .substract_left(substract_left),
        .multiply_left(multiply_left), .divide_left(divide_left)
    );

    int         checks = 0;
    int         errors = 0;
    int         dep [4] = '{D0, D1, D2, D3};
    logic [7:0] stream [4][0:511];
    int         head [4];
    int         tail [4];
    int         stall_left [4];
    logic [3:0] en;
    logic [7:0] exp_pub [4][0:31];
    logic [7:0] cur [0:31];
    int         cur_n;
    int         owner;
    int         model_last;
    logic [3:0] exp_done;
    logic [3:0] obs_done;
    logic [3:0] obs_ready;
    int         done_count;
    int         done_log [0:255];
    int         stall_at;
    int         stall_len;
    bit         rand_stall;

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(int last, logic [3:0] v);
        for (int i = 1; i <= 4; i++)
            if (v[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    function automatic logic [255:0] dut_bank(int b);
        logic [255:0] f;
        f = '0;
        case (b)
            0: f[8*D0-1:0] = add_left;
            1: f[8*D1-1:0] = substract_left;
            2: f[8*D2-1:0] = multiply_left;
            default: f[8*D3-1:0] = divide_left;
        endcase
        return f;
    endfunction

    function automatic logic [255:0] exp_bank(int b);
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < dep[b]; i++) f[i*8 +: 8] = exp_pub[b][i];
        return f;
    endfunction

    task automatic push(int r, logic [7:0] v);
        if (head[r] == tail[r]) begin
            head[r] = 0;
            tail[r] = 0;
        end
        stream[r][tail[r]] = v;
        tail[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (en[i] && head[i] < tail[i] && stall_left[i] == 0) begin
                req_valid[i] = 1'b1;
                req_data[i]  = stream[i][head[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = 8'($urandom);
            end
            if (stall_left[i] > 0) stall_left[i]--;
        end
    endtask

    task automatic cycle();
        int idx;
        drive();
        @(negedge clk);
        obs_done  = bank_done;
        obs_ready = req_ready;
        chk("ready_onehot", 256'(req_ready & (req_ready - 4'd1)), 256'(0));
        chk("bank_done", 256'(bank_done), 256'(exp_done));
        for (int b = 0; b < 4; b++) chk($sformatf("published_bank%0d", b), dut_bank(b), exp_bank(b));
        if (req_ready != 0 || bank_done != 0) chk("busy", 256'(busy), 256'(1));
        if (req_ready != 0) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
            if (owner < 0) begin
                chk("rr_winner", 256'(idx), 256'(rr_pick(model_last, req_valid)));
                owner = idx;
                cur_n = 0;
            end
            chk("ready_owner", 256'(idx), 256'(owner));
            chk("grant", 256'(grant), 256'(owner));
        end
        if (bank_done != 0) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (bank_done[i]) idx = i;
            done_log[done_count % 256] = idx;
            done_count++;
        end
        exp_done = 4'b0000;
        if (owner >= 0 && req_valid[owner] && req_ready[owner]) begin
            cur[cur_n] = req_data[owner];
            cur_n++;
            head[owner]++;
            if (cur_n == dep[owner]) begin
                for (int i = 0; i < cur_n; i++) exp_pub[owner][i] = cur[i];
                exp_done          = 4'b0001 << owner;
                model_last        = owner;
                stall_left[owner] = 0;
                owner             = -1;
            end else if (cur_n == stall_at) begin
                stall_left[owner] = stall_len;
            end else if (rand_stall && $urandom_range(0, 7) == 0) begin
                stall_left[owner] = $urandom_range(1, 4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(int n, int budget);
        int start;
        int k;
        start = done_count;
        k = 0;
        while (done_count - start < n && k < budget) begin
            cycle();
            k++;
        end
        chk("done_within_budget", 256'(done_count - start >= n), 256'(1));
    endtask

    task automatic do_reset();
        reset_l   = 1'b0;
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        reset_l    = 1'b1;
        owner      = -1;
        model_last = 3;
        exp_done   = 4'b0000;
        cur_n      = 0;
        for (int b = 0; b < 4; b++) begin
            stall_left[b] = 0;
            for (int i = 0; i < 32; i++) exp_pub[b][i] = 8'h00;
        end
    endtask

    initial begin
        int k;
        int rcount;
        int start;
        int total;
        int order [5];
        logic [15:0]  dv;
        logic [7:0]   first;
        logic [255:0] e;
        int base;

        req_data   = '0;
        en         = 4'b0000;
        done_count = 0;
        stall_at   = -1;
        stall_len  = 0;
        rand_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
        do_reset();
        do_reset();

        // Reset defaults over five idle cycles
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rst_ready", 256'(obs_ready), 256'(0));
            chk("rst_busy", 256'(busy), 256'(0));
            chk("rst_grant", 256'(grant), 256'(0));
        end

        // Single divide load, no stalls
        push(3, 8'hA1);
        push(3, 8'hB2);
        en = 4'b1000;
        k = 0;
        rcount = 0;
        while (k < 20) begin
            cycle();
            if (obs_ready == 4'b1000) rcount++;
            if (obs_done != 0) break;
            k++;
        end
        chk("divide_latency", 256'(k), 256'(4));
        chk("divide_ready_cycles", 256'(rcount), 256'(2));
        dv = 16'hB2A1;
        chk("divide_value", 256'(divide_left), 256'(dv));
        cycle();
        chk("divide_done_pulse", 256'(obs_done), 256'(0));

        // Round robin under contention, bytes = lane index
        for (int r = 0; r < 4; r++) for (int i = 0; i < dep[r]; i++) push(r, 8'(i));
        for (int i = 0; i < D0; i++) push(0, 8'(i));
        en = 4'b1111;
        start = done_count;
        run_until_done(5, 600);
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), 256'(done_log[(start + i) % 256]), 256'(order[i]));
        chk("mul_lane31", 256'(multiply_left[31]), 256'(8'd31));
        chk("add_lane11", 256'(add_left[11]), 256'(8'd11));
        en = 4'b0000;
        cycle();
        cycle();

        // Stall and hold on the multiply bank
        base = (head[2] == tail[2]) ? 0 : tail[2];
        for (int i = 0; i < D2; i++) push(2, 8'($urandom));
        base = tail[2] - D2;
        stall_at  = 16;
        stall_len = 10;
        en = 4'b0100;
        run_until_done(1, 200);
        stall_at = -1;
        e = '0;
        for (int i = 16; i < 32; i++) e[(i-16)*8 +: 8] = stream[2][base + i];
        chk("mul_upper_lanes", 256'(multiply_left[31:16]), e);
        en = 4'b0000;
        cycle();
        cycle();

        // Reset in the middle of an add burst
        for (int i = 0; i < D0; i++) push(0, 8'($urandom_range(1, 255)));
        en = 4'b0001;
        k = 0;
        while (!(owner == 0 && cur_n == 7) && k < 100) begin
            cycle();
            k++;
        end
        chk("reached_lane6", 256'(owner == 0 && cur_n == 7), 256'(1));
        do_reset();
        head[0] = tail[0];
        en = 4'b0000;
        for (int i = 0; i < 3; i++) cycle();
        chk("add_zero_after_reset", 256'(add_left), 256'(0));
        first = 8'($urandom_range(1, 255));
        push(0, first);
        for (int i = 1; i < D0; i++) push(0, 8'($urandom));
        en = 4'b0001;
        run_until_done(1, 100);
        chk("add_restart_lane0", 256'(add_left[0]), 256'(first));
        en = 4'b0000;
        cycle();
        cycle();

        // Atomic publish of the substract bank
        for (int i = 0; i < D1; i++) push(1, 8'h11);
        en = 4'b0010;
        run_until_done(1, 50);
        for (int i = 0; i < D1; i++) push(1, 8'h22);
        run_until_done(1, 50);
        chk("sub_all_22", 256'(substract_left), 256'(32'h22222222));
        en = 4'b0000;
        cycle();
        cycle();

        // Randomized bursts with random owner stalls
        rand_stall = 1'b1;
        for (int round = 0; round < 4; round++) begin
            total = 0;
            for (int r = 0; r < 4; r++) begin
                k = $urandom_range(0, 2);
                for (int b = 0; b < k; b++) begin
                    for (int i = 0; i < dep[r]; i++) push(r, 8'($urandom));
                    total++;
                end
            end
            if (total == 0) begin
                k = $urandom_range(0, 3);
                for (int i = 0; i < dep[k]; i++) push(k, 8'($urandom));
                total = 1;
            end
            en = 4'b1111;
            run_until_done(total, 4000);
            en = 4'b0000;
            cycle();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/packed_lane_loader.md
# packed_lane_loader

Loads the four packed byte-lane operand banks (add, substract, multiply, divide) that feed the lane-array arithmetic submodule. Four requesters each stream bytes into their own bank. A round-robin arbiter serialises the requesters, so one byte per cycle is written into one bank. Each bank is filled in a shadow register and published atomically to its packed output, which connects directly to the submodule's `*_left` inputs.

## Interface
Parameters:
- `W`, default 8: base lane count term.
- `K`, default 4: lane count modifier.
- Bank depths are derived, in lanes of 8 bits:
  - bank 0 (add): `W+K` = 12
  - bank 1 (substract): `W-K` = 4
  - bank 2 (multiply): `W*K` = 32
  - bank 3 (divide): `W/K` = 2
- Constraint: `W > K`, `W % K == 0`.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset_l`  in  1  synchronous, active-low reset.
- `req_valid`  in  4  per-requester byte valid; bit i is requester i.
- `req_data`  in  [3:0][7:0]  per-requester byte.
- `req_ready`  out  4  at most one bit set; only the granted requester is ever ready.
- `grant`  out  2  index of the current owner; meaningful while `busy`=1.
- `busy`  out  1  high in states ARB, LOAD and DONE.
- `bank_done`  out  4  one-cycle pulse on the bit of the bank just published.
- `add_left`  out  [W+K-1:0][7:0]  published bank 0.
- `substract_left`  out  [W-K-1:0][7:0]  published bank 1.
- `multiply_left`  out  [W*K-1:0][7:0]  published bank 2.
- `divide_left`  out  [W/K-1:0][7:0]  published bank 3.

## Operation
The FSM has four states: IDLE, ARB, LOAD, DONE.

- **IDLE**
  - If `req_valid` is non-zero, go to ARB.
- **ARB**
  - Select the first requester with `req_valid` set, searching from `last_grant+1` mod 4 upward.
  - Register the winner into `grant`, clear `lane_cnt`, go to LOAD.
  - If `req_valid` is zero in ARB, return to IDLE with `last_grant` unchanged.
- **LOAD**
  - `req_ready[grant]`=1, all other ready bits 0.
  - On `req_valid[grant] & req_ready[grant]`:
    - write `req_data[grant]` into `shadow[grant]` lane `lane_cnt`;
    - increment `lane_cnt`.
  - Lane 0 is the first byte accepted.
  - If `req_valid[grant]` is low, stall: no write, no timeout, ownership is kept.
  - A handshake on lane `depth(grant)-1` moves the FSM to DONE.
  - `req_valid` on non-granted requesters is ignored. Their data is not consumed and they must hold it.
- **DONE**
  - Copy `shadow[grant]` to the matching published output.
  - Pulse `bank_done[grant]`.
  - Set `last_grant`=`grant`, go to IDLE. `req_ready` is 0.
- **Counter and outputs**
  - `lane_cnt` is `$clog2(W*K)` bits wide (5 at default) and never exceeds `depth(grant)-1`.
  - Published outputs change only in the DONE cycle. Banks that are not being published hold their value indefinitely.
  - Lanes within a bank are written by index. No arithmetic is performed on the data.

## Timing
- **Reset**: `reset_l`=0 sampled on a rising edge has this effect on the next cycle:
  - state = IDLE;
  - all published banks and shadows = 0;
  - `req_ready`=0, `bank_done`=0, `busy`=0, `grant`=0;
  - `last_grant`=3, so requester 0 has first priority.
- **Reset mid-LOAD**: the partial shadow is discarded (zeroed), published banks are zeroed, and no `bank_done` is issued.
- **Latency**: `req_valid` rising in IDLE gives:
  - ARB on the next cycle;
  - first `req_ready` one cycle after that;
  - with no stalls, `bank_done` and the new output value appear one cycle after the last handshake.
  - Total burst cost is `depth+3` cycles, including the IDLE→ARB edge; for example, bank 1 takes 7.
- **Back-to-back**:
  - the earliest next ARB is the cycle after DONE→IDLE;
  - the minimum gap between `bank_done` pulses is 2 + next depth cycles of LOAD, plus 1.
- **`req_ready`** is a registered function of state and `grant`, with no combinational path from `req_valid`.
- **Simultaneous requests**: all four assert together → grant order 0,1,2,3,0,… while all remain asserted.

## Test plan
- **Reset defaults**: reset, then 5 idle cycles → all outputs 0, `busy`=0, `req_ready`=0.
- **Single divide load, no stalls**: requester 3 only, bytes 0xA1, 0xB2 → `req_ready`=4'b1000 for 2 cycles; next cycle `divide_left`={8'hB2,8'hA1} and `bank_done`=4'b1000 for 1 cycle; other banks stay 0.
- **Round-robin under contention**: all four valid continuously, bytes = lane index → `bank_done` order 0,1,2,3,0; `multiply_left[31]`=8'd31; `add_left[11]`=8'd11; ready never asserted for more than one requester.
- **Stall and hold**: requester 2 drops valid for 10 cycles after lane 15 → no write and `lane_cnt` held; `multiply_left` unchanged until `bank_done[2]`; final lanes 16..31 are correct.
- **Reset mid-burst**: requester 0 loaded to lane 6, then `reset_l` pulsed for one cycle → no `bank_done`, `add_left`=0; the next request from requester 0 starts at lane 0.
- **Atomic publish**: preload `substract_left` with 0x11×4, then reload with 0x22×4 → the output reads all 0x11 until the DONE cycle and all 0x22 afterwards, never a mix.
